// File: rtl/conv_layer_scheduler.sv
// conv_layer_scheduler: sequences input/weight loads, per-channel conv and per-channel result stores
// over a one-chunk-outstanding DMA command port. Define CONV_SCHED_CYCLE_CNT_EN to add the o_cycle_cnt busy counter.
module conv_layer_scheduler #(
  parameter int ADDR_WIDTH    = 15,
  parameter int IN_BASE       = 0,
  parameter int IN_BYTES      = 1024,
  parameter int WGT_BYTES     = 256,
  parameter int OUT_BASE      = 1280,
  parameter int OUT_CH_STRIDE = 288,
  parameter int N_CH          = 8,
  parameter int BURST         = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic                     o_finish,
  output logic                     o_err,
  output logic                     o_cmd_valid,
  input  logic                     i_cmd_ready,
  output logic                     o_cmd_write,
  output logic [ADDR_WIDTH-1:0]    o_cmd_addr,
  output logic [7:0]               o_cmd_len,
  input  logic                     i_cmd_done,
  input  logic                     i_cmd_err,
  output logic                     o_conv_start,
  output logic [$clog2(N_CH)-1:0]  o_conv_ch,
  input  logic                     i_conv_done
`ifdef CONV_SCHED_CYCLE_CNT_EN
  ,
  output logic [31:0]              o_cycle_cnt
`endif
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int REM_W = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LD_IN, S_LD_W, S_CONV, S_ST, S_DONE, S_ERR
  } state_t;

  state_t                r_state;
  logic [CH_W-1:0]       r_ch;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_out_base;
  logic [REM_W-1:0]      r_rem;
  logic                  r_issue;
  logic                  r_outstanding;
  logic                  r_cmd_valid;
  logic                  r_cmd_write;
  logic [ADDR_WIDTH-1:0] r_cmd_addr;
  logic [7:0]            r_cmd_len;
  logic                  r_conv_start;
  logic                  r_busy;
  logic                  r_finish;
  logic                  r_err;
  logic [8:0]            w_beats;
  logic                  w_start_acc;

  assign w_beats     = (r_rem < REM_W'(BURST)) ? r_rem[8:0] : 9'(BURST);
  assign w_start_acc = i_start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);

  // r_addr/r_rem describe the next chunk to issue; r_issue launches it one cycle after a phase load or cmd_done.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_ch          <= '0;
      r_addr        <= '0;
      r_out_base    <= '0;
      r_rem         <= '0;
      r_issue       <= 1'b0;
      r_outstanding <= 1'b0;
      r_cmd_valid   <= 1'b0;
      r_cmd_write   <= 1'b0;
      r_cmd_addr    <= '0;
      r_cmd_len     <= '0;
      r_conv_start  <= 1'b0;
      r_busy        <= 1'b0;
      r_finish      <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_conv_start <= 1'b0;
      if (r_issue) begin
        r_issue     <= 1'b0;
        r_cmd_valid <= 1'b1;
        r_cmd_write <= (r_state == S_ST);
        r_cmd_addr  <= r_addr;
        r_cmd_len   <= 8'(w_beats - 9'd1);
        r_addr      <= r_addr + ADDR_WIDTH'(w_beats);
        r_rem       <= r_rem - REM_W'(w_beats);
      end
      if (r_cmd_valid && i_cmd_ready) begin
        r_cmd_valid   <= 1'b0;
        r_outstanding <= 1'b1;
      end
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            r_state    <= S_LD_IN;
            r_ch       <= '0;
            r_out_base <= ADDR_WIDTH'(OUT_BASE);
            r_addr     <= ADDR_WIDTH'(IN_BASE);
            r_rem      <= REM_W'(IN_BYTES);
            r_issue    <= 1'b1;
            r_busy     <= 1'b1;
            r_finish   <= 1'b0;
            r_err      <= 1'b0;
          end
        end
        S_LD_IN, S_LD_W, S_ST: begin
          if (r_outstanding && i_cmd_done) begin
            r_outstanding <= 1'b0;
            if (i_cmd_err) begin
              r_state  <= S_ERR;
              r_busy   <= 1'b0;
              r_finish <= 1'b1;
              r_err    <= 1'b1;
            end else if (r_rem != '0) begin
              r_issue <= 1'b1;
            end else if (r_state == S_LD_IN) begin
              r_state <= S_LD_W;
              r_addr  <= ADDR_WIDTH'(IN_BASE + IN_BYTES);
              r_rem   <= REM_W'(WGT_BYTES);
              r_issue <= 1'b1;
            end else if (r_state == S_LD_W) begin
              r_state      <= S_CONV;
              r_conv_start <= 1'b1;
            end else if (r_ch == CH_W'(N_CH - 1)) begin
              r_state  <= S_DONE;
              r_busy   <= 1'b0;
              r_finish <= 1'b1;
            end else begin
              r_state      <= S_CONV;
              r_ch         <= r_ch + CH_W'(1);
              r_out_base   <= r_out_base + ADDR_WIDTH'(OUT_CH_STRIDE);
              r_conv_start <= 1'b1;
            end
          end
        end
        S_CONV: begin
          // conv_done coinciding with the conv_start pulse belongs to nothing we asked for
          if (!r_conv_start && i_conv_done) begin
            r_state <= S_ST;
            r_addr  <= r_out_base;
            r_rem   <= REM_W'(OUT_CH_STRIDE);
            r_issue <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CONV_SCHED_CYCLE_CNT_EN
  logic [31:0] r_cycle_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_cycle_cnt <= '0;
    else if (w_start_acc)
      r_cycle_cnt <= '0;
    else if (r_busy && r_cycle_cnt != 32'hFFFF_FFFF)
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
  end

  assign o_cycle_cnt = r_cycle_cnt;
`endif

  assign o_busy       = r_busy;
  assign o_finish     = r_finish;
  assign o_err        = r_err;
  assign o_cmd_valid  = r_cmd_valid;
  assign o_cmd_write  = r_cmd_write;
  assign o_cmd_addr   = r_cmd_addr;
  assign o_cmd_len    = r_cmd_len;
  assign o_conv_start = r_conv_start;
  assign o_conv_ch    = r_ch;

endmodule
